fc_transition_scheduler: RTL and testbench



---
 rtl/fc_sched_pkg.sv | 17 +
 rtl/fc_rr_arbiter.sv | 36 +++
 rtl/fc_transition_scheduler.sv | 105 ++++++++++
 tb/tb_fc_transition_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_sched_pkg.sv
// Shared types and helpers for the free-choice transition scheduler.
package fc_sched_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRE   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // Bit offset of transition t's preset mask inside the packed PRESET vector.
    function automatic int unsigned preset_base(input int unsigned t, input int unsigned num_places);
        return t * num_places;
    endfunction

endpackage

// File: rtl/fc_rr_arbiter.sv
// Combinational round-robin arbiter: first candidate searching upward from ptr+1, wrapping.
module fc_rr_arbiter #(
    parameter int unsigned N = 8,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     cand,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic              found;
    logic [IDX_W-1:0]  pos;
    int unsigned       sum;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        sum       = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            sum = 32'(ptr) + k;
            if (sum >= N) begin
                sum = sum - N;
            end
            pos = IDX_W'(sum);
            if (!found && cand[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                grant_idx  = pos;
            end
        end
    end

endmodule

// File: rtl/fc_transition_scheduler.sv
// Firing controller for decomposed free-choice FSMs: grants one enabled, requested
// transition at a time, waits for the marking to settle, and flags deadlock.
module fc_transition_scheduler
    import fc_sched_pkg::*;
#(
    parameter int unsigned                       NUM_PLACES      = 10,
    parameter int unsigned                       NUM_TRANS       = 8,
    parameter logic [NUM_TRANS*NUM_PLACES-1:0]   PRESET          = '0,
    parameter int unsigned                       SETTLE          = 1,
    parameter int unsigned                       DEADLOCK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_PLACES-1:0] places,
    input  logic [NUM_TRANS-1:0]  req,
    output logic [NUM_TRANS-1:0]  fire,
    output logic [NUM_TRANS-1:0]  ack,
    output logic                  busy,
    output logic                  deadlock
);

    localparam int unsigned IDX_W = (NUM_TRANS > 1) ? $clog2(NUM_TRANS) : 1;
    localparam int unsigned DL_W  = $clog2(DEADLOCK_CYCLES + 1);
    localparam int unsigned SET_W = 4;

    logic [NUM_TRANS-1:0] enabled;
    logic [NUM_TRANS-1:0] cand;
    logic [NUM_TRANS-1:0] grant;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     rr_ptr;
    state_t               state;
    logic [SET_W-1:0]     settle_cnt;
    logic [DL_W-1:0]      dl_cnt;

    // Empty presets never enable a transition.
    for (genvar t = 0; t < NUM_TRANS; t++) begin : g_enable
        localparam int unsigned            BASE = preset_base(t, NUM_PLACES);
        localparam logic [NUM_PLACES-1:0]  PRE  = PRESET[BASE +: NUM_PLACES];
        assign enabled[t] = ((places & PRE) == PRE) && (PRE != '0);
    end

    assign cand = req & enabled;

    fc_rr_arbiter #(.N(NUM_TRANS)) u_arb (
        .cand      (cand),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign ack = fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            rr_ptr     <= IDX_W'(NUM_TRANS - 1);
            fire       <= '0;
            busy       <= 1'b0;
            deadlock   <= 1'b0;
            settle_cnt <= '0;
            dl_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Deadlock watch looks at marking only, not at requests.
                    if (enabled == '0) begin
                        if (dl_cnt != DL_W'(DEADLOCK_CYCLES)) begin
                            dl_cnt <= dl_cnt + DL_W'(1);
                        end
                        if (dl_cnt == DL_W'(DEADLOCK_CYCLES - 1)) begin
                            deadlock <= 1'b1;
                        end
                    end else begin
                        dl_cnt <= '0;
                    end
                    if (cand != '0) begin
                        fire   <= grant;
                        rr_ptr <= grant_idx;
                        busy   <= 1'b1;
                        state  <= ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    fire       <= '0;
                    settle_cnt <= SET_W'(SETTLE);
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt <= SET_W'(1)) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                default: begin
                    fire  <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_transition_scheduler.sv
// Self-checking bench for fc_transition_scheduler with a behavioural scheduling model.
module tb_fc_transition_scheduler;

    localparam int NP  = 4;
    localparam int NT  = 4;
    localparam int SET = 1;
    localparam int DLC = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NP-1:0] places = '0;
    logic [NT-1:0] req = '0;
    logic [NT-1:0] fire;
    logic [NT-1:0] ack;
    logic          busy;
    logic          deadlock;

    int vectors = 0;
    int miscompares = 0;

    // Model state: cycles still blocked after a grant, last winner, empty-IDLE run length.
    int       m_blocked;
    int       m_last;
    int       m_empty;
    bit       m_dl;
    logic [NT-1:0] m_fire;
    logic [NP-1:0] preset [NT];

    fc_transition_scheduler #(
        .NUM_PLACES      (NP),
        .NUM_TRANS       (NT),
        .PRESET          (16'b1100_0010_0001_0001),
        .SETTLE          (SET),
        .DEADLOCK_CYCLES (DLC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .places   (places),
        .req      (req),
        .fire     (fire),
        .ack      (ack),
        .busy     (busy),
        .deadlock (deadlock)
    );

    always #5 clk = ~clk;

    function automatic logic [NT-1:0] model_enabled(input logic [NP-1:0] p);
        logic [NT-1:0] e;
        e = '0;
        for (int t = 0; t < NT; t++) begin
            e[t] = ((p & preset[t]) == preset[t]) && (preset[t] != '0);
        end
        return e;
    endfunction

    task automatic model_reset();
        m_blocked = 0;
        m_last    = NT - 1;
        m_empty   = 0;
        m_dl      = 1'b0;
        m_fire    = '0;
    endtask

    // Advance one clock; model consumes the inputs present at the edge.
    task automatic tick();
        logic [NT-1:0] en;
        logic [NT-1:0] c;
        int w;
        @(posedge clk);
        m_fire = '0;
        if (m_blocked == 0) begin
            en = model_enabled(places);
            c  = req & en;
            if (en == '0) begin
                if (m_empty < DLC) m_empty++;
                if (m_empty == DLC) m_dl = 1'b1;
            end else begin
                m_empty = 0;
            end
            if (c != '0) begin
                w = -1;
                for (int k = 1; k <= NT; k++) begin
                    if (w < 0 && c[(m_last + k) % NT]) w = (m_last + k) % NT;
                end
                m_fire    = NT'(1) << w;
                m_last    = w;
                m_blocked = 1 + SET;
            end
        end else begin
            m_blocked--;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        places = '0;
        req    = '0;
        reset  = 1'b1;
        @(negedge clk);
        vectors++;
        if (fire !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0 || deadlock !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: fire=%b ack=%b busy=%b deadlock=%b, want 0000 0000 0 0",
                     fire, ack, busy, deadlock);
        end
        do_reset();
    endtask

    task automatic test_single_fire();
        do_reset();
        places = 4'b0001;
        req    = 4'b0001;
        tick();
        vectors++;
        if (fire !== 4'b0001 || ack !== 4'b0001 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_fire: fire=%b ack=%b busy=%b, want 0001 0001 1", fire, ack, busy);
        end
        req = 4'b0000;
        tick();
        vectors++;
        if (fire !== 4'b0000 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_settle: fire=%b busy=%b, want 0000 1", fire, busy);
        end
        req = 4'b0001;
        tick();
        vectors++;
        if (fire !== 4'b0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle: fire=%b busy=%b, want 0000 0", fire, busy);
        end
        tick();
        vectors++;
        if (fire !== 4'b0001 || fire !== m_fire) begin
            miscompares++;
            $display("FAIL single_refire: fire=%b, want %b", fire, m_fire);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_conflict();
        logic [NT-1:0] seq [4];
        int n;
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0001; seq[3] = 4'b0010;
        do_reset();
        places = 4'b0001;
        req    = 4'b0011;
        n = 0;
        for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
            tick();
            vectors++;
            if ($countones(fire) > 1 || fire !== m_fire) begin
                miscompares++;
                $display("FAIL conflict_cycle: fire=%b, want %b", fire, m_fire);
            end
            if (fire != '0) begin
                vectors++;
                if (fire !== seq[n]) begin
                    miscompares++;
                    $display("FAIL conflict_order[%0d]: fire=%b, want %b", n, fire, seq[n]);
                end
                n++;
            end
        end
        vectors++;
        if (n != 4) begin
            miscompares++;
            $display("FAIL conflict_count: fires=%0d, want 4 within budget", n);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_join();
        do_reset();
        places = 4'b0100;
        req    = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (fire !== 4'b0000) begin
                miscompares++;
                $display("FAIL join_blocked: fire=%b, want 0000", fire);
            end
        end
        places = 4'b1100;
        tick();
        vectors++;
        if (fire !== 4'b1000) begin
            miscompares++;
            $display("FAIL join_fire: fire=%b, want 1000", fire);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_deadlock();
        do_reset();
        places = 4'b0000;
        req    = 4'b1111;
        for (int i = 1; i <= DLC; i++) begin
            tick();
            if (i >= DLC - 1) begin
                vectors++;
                if (deadlock !== (i == DLC) || deadlock !== m_dl) begin
                    miscompares++;
                    $display("FAIL deadlock_after_%0d: deadlock=%b, want %b", i, deadlock, (i == DLC));
                end
            end
        end
        places = 4'b0001;
        req    = 4'b0001;
        tick();
        vectors++;
        if (fire !== 4'b0001 || deadlock !== 1'b1) begin
            miscompares++;
            $display("FAIL deadlock_recover: fire=%b deadlock=%b, want 0001 1", fire, deadlock);
        end
        req = '0;
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (deadlock !== 1'b1) begin
            miscompares++;
            $display("FAIL deadlock_sticky: deadlock=%b, want 1", deadlock);
        end
    endtask

    task automatic test_reset_mid_fire();
        do_reset();
        places = 4'b0010;
        req    = 4'b0100;
        tick();
        vectors++;
        if (fire !== 4'b0100) begin
            miscompares++;
            $display("FAIL midfire_setup: fire=%b, want 0100", fire);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (fire !== 4'b0000 || ack !== 4'b0000) begin
            miscompares++;
            $display("FAIL midfire_async: fire=%b ack=%b, want 0000 0000", fire, ack);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        vectors++;
        if (busy !== 1'b0 || deadlock !== 1'b0) begin
            miscompares++;
            $display("FAIL midfire_idle: busy=%b deadlock=%b, want 0 0", busy, deadlock);
        end
        places = 4'b0011;
        req    = 4'b0111;
        tick();
        vectors++;
        if (fire !== 4'b0001) begin
            miscompares++;
            $display("FAIL midfire_priority: fire=%b, want 0001", fire);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 3) == 0) places = NP'($urandom_range(0, 15));
            req = (req & ~ack) | (NT'($urandom_range(0, 15)) & NT'($urandom_range(0, 15)));
            if ($urandom_range(0, 9) == 0) req = req & NT'($urandom_range(0, 15));
            tick();
            vectors++;
            if (fire !== m_fire || ack !== m_fire || busy !== (m_blocked != 0) || deadlock !== m_dl) begin
                miscompares++;
                $display("FAIL random_cyc%0d: fire=%b ack=%b busy=%b dl=%b, want %b %b %b %b",
                         cyc, fire, ack, busy, deadlock, m_fire, m_fire, (m_blocked != 0), m_dl);
            end
        end
        req = '0;
    endtask

    initial begin
        preset[0] = 4'b0001;
        preset[1] = 4'b0001;
        preset[2] = 4'b0010;
        preset[3] = 4'b1100;
        model_reset();
        test_reset();
        test_single_fire();
        test_conflict();
        test_join();
        test_deadlock();
        test_reset_mid_fire();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
